// File: rtl/screen_mem_arb_pkg.sv
// Shared constants and state type for the screen memory arbiter.
// Depth covers 6144 bitmap bytes plus 768 attribute bytes.
package screen_mem_arb_pkg;

   localparam int DEPTH_DEF  = 6912;
   localparam int ADDR_W_DEF = 13;

   localparam logic [7:0]  OOB_RDATA = 8'hFF;
   localparam logic [15:0] CONT_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/screen_mem_arb.sv
// Single-port screen BRAM arbiter: video fetch always wins, CPU access waits in PEND.
// CPU ack two cycles after request when video is idle; video data valid two cycles after fetch.
module screen_mem_arb
   import screen_mem_arb_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_rd,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic [15:0]       contention
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [7:0]        r_wdata;
   logic              r_vid_pend;
   logic [7:0]        r_vid_data;
   logic [15:0]       r_contention;

   logic              w_capture;
   logic              w_issue;
   logic              w_stall;
   logic              w_in_range;

   always_comb begin
      w_capture  = (r_state == IDLE) && cpu_req;
      w_issue    = (r_state == PEND) && !vid_rd;
      w_stall    = (r_state == PEND) && vid_rd;
      w_in_range = in_range(32'(r_addr), DEPTH);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (cpu_req) w_state_nxt = PEND;
         PEND:    if (!vid_rd) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding registers keep the CPU access stable while video owns the port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= 8'h00;
      end else if (w_capture) begin
         r_addr  <= cpu_addr;
         r_we    <= cpu_we;
         r_wdata <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_contention <= 16'h0000;
      end else if (w_stall && (r_contention != CONT_MAX)) begin
         r_contention <= r_contention + 16'd1;
      end
   end

   // BRAM data lags the address by one cycle, so the load is delayed by a flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vid_pend <= 1'b0;
         r_vid_data <= 8'h00;
      end else begin
         r_vid_pend <= vid_rd;
         if (r_vid_pend) begin
            r_vid_data <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_addr  = w_issue ? r_addr : vid_addr;
      mem_we    = reset && w_issue && r_we && w_in_range;
      mem_wdata = r_wdata;
      cpu_ack   = reset && (r_state == RESP);
      cpu_rdata = 8'h00;
      if (cpu_ack && !r_we) begin
         cpu_rdata = w_in_range ? mem_rdata : OOB_RDATA;
      end
      cpu_wait   = (r_state == PEND) || ((r_state == IDLE) && cpu_req);
      vid_data   = r_vid_data;
      contention = r_contention;
   end

endmodule

// File: tb/tb_screen_mem_arb.sv
// Bench for screen_mem_arb: BRAM model, per-cycle reference model, directed and random traffic.
module tb_screen_mem_arb;
   import screen_mem_arb_pkg::*;

   localparam int DEPTH = 6912;
   localparam int AW    = 13;

   logic          clk = 1'b0;
   logic          reset, vid_rd, cpu_req, cpu_we;
   logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
   logic [7:0]    cpu_wdata, vid_data, cpu_rdata, mem_wdata, mem_rdata;
   logic          cpu_ack, cpu_wait, mem_we;
   logic [15:0]   contention;

   logic          pl_we;
   int            pl_addr;
   logic [7:0]    pl_dat;
   logic [7:0]    bram [DEPTH];

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   screen_mem_arb #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .contention(contention)
   );

   // Single-port BRAM with one-cycle read latency plus a preload port.
   always @(posedge clk) begin
      if (pl_we) bram[pl_addr] <= pl_dat;
      else if (mem_we && int'(mem_addr) < DEPTH) bram[int'(mem_addr)] <= mem_wdata;
      mem_rdata <= (int'(mem_addr) < DEPTH) ? bram[int'(mem_addr)] : 8'h00;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one open CPU access, served at the first video-free cycle.
   bit            m_open = 0, m_served = 0, m_we = 0;
   logic [AW-1:0] m_addr = '0;
   logic [7:0]    m_wdata = 8'h00, m_rexp = 8'h00, m_vid = 8'h00, p1_d = 8'h00;
   bit            p1_v = 0;
   int            m_cont = 0;
   logic [7:0]    shadow [DEPTH];

   always @(negedge clk) begin
      bit            acc_now, exp_we;
      logic [AW-1:0] exp_addr;
      if (chk_on) begin
         acc_now  = m_open && !m_served && !vid_rd;
         exp_addr = acc_now ? m_addr : vid_addr;
         exp_we   = reset && acc_now && m_we && (int'(m_addr) < DEPTH);
         check("mem_addr", 32'(mem_addr), 32'(exp_addr));
         check("mem_we", 32'(mem_we), 32'(exp_we));
         if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
         check("cpu_wait", 32'(cpu_wait), 32'((m_open && !m_served) || (!m_open && cpu_req)));
         check("cpu_ack", 32'(cpu_ack), 32'(reset && m_served));
         check("cpu_rdata", 32'(cpu_rdata), (reset && m_served) ? 32'(m_rexp) : 32'h0);
         check("contention", 32'(contention), 32'(m_cont));
         check("vid_data", 32'(vid_data), 32'(m_vid));
         if (!reset) begin
            m_open = 0; m_served = 0; m_cont = 0; m_vid = 8'h00; p1_v = 0;
         end else begin
            if (p1_v) m_vid = p1_d;
            p1_v = vid_rd;
            p1_d = shadow[int'(vid_addr)];
            if (m_served) begin
               m_open = 0; m_served = 0;
            end else if (m_open) begin
               if (!vid_rd) begin
                  m_served = 1;
                  if (m_we) m_rexp = 8'h00;
                  else if (int'(m_addr) >= DEPTH) m_rexp = 8'hFF;
                  else m_rexp = shadow[int'(m_addr)];
                  if (m_we && int'(m_addr) < DEPTH) shadow[int'(m_addr)] = m_wdata;
               end else if (m_cont < 65535) begin
                  m_cont++;
               end
            end else if (cpu_req) begin
               m_open = 1; m_addr = cpu_addr; m_we = cpu_we; m_wdata = cpu_wdata;
            end
         end
      end
      if (pl_we) shadow[pl_addr] = pl_dat;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   // One CPU access with vid_rd low; reports data, ack latency and whether mem_we was seen.
   task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat, output bit saw_we);
      rd = 8'h00; lat = -1; saw_we = 0;
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int k = 0; k < 20; k++) begin
         settle();
         if (mem_we) saw_we = 1;
         if (cpu_ack) begin
            rd = cpu_rdata; lat = k;
            break;
         end
         tick();
      end
      tick();
      cpu_req = 0; cpu_we = 0;
   endtask

   task automatic rnd_fields();
      int r;
      r = $urandom_range(0, 3);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_wdata = 8'($urandom);
      if (r == 0)      cpu_addr = AW'(32'h300 + $urandom_range(0, 7));
      else if (r == 1) cpu_addr = AW'(DEPTH - 4 + $urandom_range(0, 7));
      else             cpu_addr = AW'($urandom_range(0, 8191));
   endtask

   initial begin
      logic [7:0] rd;
      int         lat, waitc;
      bit         sw, active, saw_ack;
      reset = 0; vid_rd = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0;
      cpu_addr = '0; cpu_wdata = 8'h00; pl_we = 0; pl_addr = 0; pl_dat = 8'h00;
      tick();
      chk_on = 1;
      for (int i = 0; i < DEPTH; i++) begin
         pl_we = 1; pl_addr = i;
         pl_dat = (i == 32'h20) ? 8'h3C : (i == 32'h200) ? 8'h5A : 8'($urandom);
         tick();
      end
      pl_we = 0;
      settle();
      check("rst_vid_data", 32'(vid_data), 32'h0);
      check("rst_ack", 32'(cpu_ack), 32'h0);
      check("rst_rdata", 32'(cpu_rdata), 32'h0);
      check("rst_cont", 32'(contention), 32'h0);
      tick();
      reset = 1;

      // Write then read back through the arbiter.
      do_op(1, 13'h0100, 8'hA5, rd, lat, sw);
      check("wr_lat", 32'(lat), 32'd2);
      check("wr_mem_we", 32'(sw), 32'd1);
      check("wr_rdata", 32'(rd), 32'h00);
      tick();
      do_op(0, 13'h0100, 8'h00, rd, lat, sw);
      check("rd_lat", 32'(lat), 32'd2);
      check("rd_data", 32'(rd), 32'hA5);

      // CPU read stalled behind five video fetches.
      reset = 0; tick(); reset = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1800;
      settle();
      check("st_wait0", 32'(cpu_wait), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         tick(); vid_rd = 1; vid_addr = AW'(32'h40 + k);
         settle();
         check("st_wait", 32'(cpu_wait), 32'd1);
         check("st_noack", 32'(cpu_ack), 32'd0);
      end
      tick(); vid_rd = 0;
      settle();
      check("st_wait6", 32'(cpu_wait), 32'd1);
      check("st_noack6", 32'(cpu_ack), 32'd0);
      tick(); settle();
      check("st_ack", 32'(cpu_ack), 32'd1);
      check("st_cont", 32'(contention), 32'd5);
      tick(); cpu_req = 0;

      // Video fetch of a preloaded byte, then hold.
      tick(); vid_rd = 1; vid_addr = 13'h0020;
      tick(); vid_rd = 0; vid_addr = 13'h0021;
      tick(); settle();
      check("vid_n2", 32'(vid_data), 32'h3C);
      tick(); settle();
      check("vid_hold", 32'(vid_data), 32'h3C);
      tick();

      // Out-of-range write suppressed, read returns the fill value.
      do_op(1, 13'h1B00, 8'h77, rd, lat, sw);
      check("oob_wr_we", 32'(sw), 32'd0);
      check("oob_wr_lat", 32'(lat), 32'd2);
      tick();
      do_op(0, 13'h1B00, 8'h00, rd, lat, sw);
      check("oob_rd", 32'(rd), 32'hFF);
      check("oob_rd_lat", 32'(lat), 32'd2);

      // Reset while a write is pending discards it.
      vid_rd = 1; vid_addr = 13'h0005;
      cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0200; cpu_wdata = 8'h99;
      tick(); tick();
      reset = 0; vid_rd = 0;
      settle();
      check("rp_we", 32'(mem_we), 32'd0);
      check("rp_ack", 32'(cpu_ack), 32'd0);
      tick();
      reset = 1; cpu_req = 0; cpu_we = 0;
      settle();
      check("rp_ack2", 32'(cpu_ack), 32'd0);
      check("rp_cont", 32'(contention), 32'd0);
      check("rp_vid", 32'(vid_data), 32'd0);
      check("rp_wait", 32'(cpu_wait), 32'd0);
      tick(); settle();
      check("rp_ack3", 32'(cpu_ack), 32'd0);
      tick();
      do_op(0, 13'h0200, 8'h00, rd, lat, sw);
      check("rp_mem_kept", 32'(rd), 32'h5A);

      // Contention saturates instead of wrapping.
      reset = 0; tick(); reset = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0010; vid_rd = 1; vid_addr = 13'h0011;
      for (int i = 0; i < 65540; i++) tick();
      settle();
      check("sat_cont", 32'(contention), 32'hFFFF);
      tick(); vid_rd = 0;
      tick(); settle();
      check("sat_ack", 32'(cpu_ack), 32'd1);
      check("sat_cont2", 32'(contention), 32'hFFFF);
      tick(); cpu_req = 0;

      // Random mixed traffic, checked by the reference model every cycle.
      active = 0; saw_ack = 0; waitc = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset    = ($urandom_range(0, 199) != 0);
         vid_rd   = ($urandom_range(0, 9) < 4);
         vid_addr = AW'($urandom_range(0, DEPTH - 1));
         if (active && saw_ack) begin
            if ($urandom_range(0, 1) == 1) begin
               cpu_req = 0; active = 0;
            end else begin
               rnd_fields();
            end
         end else if (!active && $urandom_range(0, 2) == 0) begin
            active = 1; cpu_req = 1; rnd_fields();
         end
         settle();
         saw_ack = cpu_ack;
         if (!active || cpu_ack) waitc = 0;
         else waitc++;
         if (waitc > 200) begin
            check("rand_timeout", 32'(waitc), 32'd0);
            waitc = 0;
         end
      end
      tick();
      cpu_req = 0; vid_rd = 0;
      tick(); tick();
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/screen_mem_arb.md
SCREEN_MEM_ARB -- requirements
Module: screen_mem_arb

Interface
REQ-001 Parameter DEPTH, default 6912, SHALL set the number of screen bytes: 6144 bitmap plus 768 attribute.
REQ-002 Parameter ADDR_W, default 13, SHALL set the width of all address ports.
REQ-003 Port clk, input, 1, SHALL be the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port vid_rd, input, 1, SHALL be the video fetch strobe; when high, the video stage owns the memory port this cycle.
REQ-006 Port vid_addr, input, ADDR_W, SHALL be the video byte address.
REQ-007 Port vid_data, output, 8, SHALL carry registered video read data.
REQ-008 Port cpu_req, input, 1, SHALL be the CPU access request (level); it is held with stable addr/we/wdata until cpu_ack.
REQ-009 Ports cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, 8) SHALL carry the CPU write enable, address and write data.
REQ-010 Port cpu_rdata, output, 8, SHALL carry CPU read data, valid while cpu_ack is high.
REQ-011 Port cpu_ack, output, 1, SHALL pulse for one cycle per completed CPU access.
REQ-012 Port cpu_wait, output, 1, SHALL be the combinational CPU stall indication (Z80 WAIT source).
REQ-013 Ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, 8) and mem_rdata (input, 8) SHALL form the single-port BRAM interface; read data appears one cycle after the address.
REQ-014 Port contention, output, 16, SHALL be a saturating count of cycles a captured CPU access waited on video.

Function
REQ-015 Video access SHALL have absolute priority: vid_rd=1 drives mem_addr=vid_addr and mem_we=0.
REQ-016 For vid_rd=1 in cycle N, vid_data SHALL load mem_rdata at the end of N+1 (valid from N+2); otherwise vid_data SHALL hold its value.
REQ-017 The FSM SHALL have states IDLE, PEND and RESP.
REQ-018 IDLE: when cpu_req=1, the block SHALL capture addr, we and wdata into holding registers and go to PEND.
REQ-019 PEND: when vid_rd=0, the block SHALL drive the held access onto the memory port and go to RESP; when vid_rd=1, it SHALL stay in PEND and increment contention.
REQ-020 RESP: cpu_ack SHALL be 1 and cpu_rdata SHALL equal mem_rdata for reads and 0x00 for writes; the FSM SHALL then return to IDLE.
REQ-021 Minimum latency with vid_rd low: req in cycle N SHALL produce the access in N+1 and cpu_ack in N+2.
REQ-022 cpu_req still high in the cycle after cpu_ack SHALL be treated as a new request.
REQ-023 cpu_wait SHALL equal (state==PEND) or (state==IDLE and cpu_req).
REQ-024 cpu_addr >= DEPTH: a write SHALL be suppressed (mem_we=0) and a read SHALL return 0xFF; cpu_ack SHALL still pulse.
REQ-025 mem_we SHALL be 1 only in a PEND cycle with vid_rd=0, held we=1 and address in range.
REQ-026 contention SHALL saturate at 0xFFFF and never wrap.
REQ-027 With no access issued, mem_addr SHALL equal vid_addr and mem_we SHALL be 0.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL set state=IDLE, vid_data=0x00, cpu_rdata=0x00, cpu_ack=0, contention=0 and holding registers to 0.
REQ-029 A reset during PEND or RESP SHALL discard the access: no ack, no write.
REQ-030 mem_we SHALL be 0 in every cycle where reset=0.

Structure
REQ-031 A shared package SHALL hold the DEPTH and ADDR_W defaults, the state enum (IDLE/PEND/RESP) and the out-of-range read value 0xFF.
REQ-032 The block SHALL contain no sub-module; the BRAM SHALL be instantiated by the parent alongside the video stage.

Verification
REQ-033 The bench SHALL cover: vid_rd=0, CPU write 0xA5 to 0x0100 -> mem_we=1 in N+1, ack in N+2; a later read of 0x0100 -> cpu_rdata=0xA5 with ack.
REQ-034 The bench SHALL cover: vid_rd held high 5 cycles while CPU reads 0x1800 -> cpu_wait high throughout, ack 2 cycles after vid_rd falls, contention=5.
REQ-035 The bench SHALL cover: vid_rd pulse at 0x0020, preloaded 0x3C -> vid_data=0x3C two cycles later, then held.
REQ-036 The bench SHALL cover: CPU write 0x1B00 (>=6912) -> no mem_we, ack pulses; a read of 0x1B00 returns 0xFF.
REQ-037 The bench SHALL cover: reset low in PEND -> no ack, no mem_we, outputs at reset values; with 0x10000 forced stall cycles, contention=0xFFFF.
